// File: rtl/imm_inst_encoder_pkg.sv
// Shared RV32I opcode constants and encoder types, also imported by the core decoder.
// Immediate range/opcode error reporting is enabled by defining IMM_RANGE_CHECK_EN.
package imm_inst_encoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] FUNCT3_SR = 3'b101;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_NONE
  } fmt_e;

  // Immediate/funct7 bits plus which plain fields the top must merge in.
  typedef struct packed {
    logic [31:0] bits;
    logic        use_op;
    logic        use_rd;
    logic        use_funct3;
    logic        use_rs1;
    logic        use_rs2;
    logic        err;
  } pack_t;

  function automatic fmt_e fmt_of(input logic [6:0] op, input logic [2:0] f3);
    fmt_e f;
    case (op)
      OP_LOAD, OP_JALR:  f = FMT_I;
      OP_IMM:            f = (f3 == FUNCT3_SR) ? FMT_SH : FMT_I;
      OP_STORE:          f = FMT_S;
      OP_BRANCH:         f = FMT_B;
      OP_LUI, OP_AUIPC:  f = FMT_U;
      OP_JAL:            f = FMT_J;
      OP_REG:            f = FMT_R;
      default:           f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_inst_encoder_pack.sv
// Combinational immediate packer: places imm/funct7 bits per instruction format.
// Range and unsupported-opcode errors are reported only when IMM_RANGE_CHECK_EN is defined.
module imm_pack
  import imm_inst_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output pack_t       pk
);

  function automatic logic fits_s12(input logic signed [31:0] v);
    return (v >= -32'sd2048) && (v <= 32'sd2047);
  endfunction

  function automatic logic fits_s20(input logic signed [31:0] v);
    return (v >= -32'sd524288) && (v <= 32'sd524287);
  endfunction

  function automatic logic fits_u5(input logic [31:0] v);
    return v[31:5] == '0;
  endfunction

  fmt_e fmt;
  logic range_bad;

  always_comb begin
    pk        = '0;
    range_bad = 1'b0;
    fmt       = fmt_of(opcode, funct3);
    pk.use_op = 1'b1;
    case (fmt)
      FMT_I: begin
        pk.bits[31:20] = imm[11:0];
        pk.use_rd      = 1'b1;
        pk.use_funct3  = 1'b1;
        pk.use_rs1     = 1'b1;
        range_bad      = !fits_s12($signed(imm));
      end
      FMT_SH: begin
        pk.bits[24:20] = imm[4:0];
        pk.bits[31:25] = funct7;
        pk.use_rd      = 1'b1;
        pk.use_funct3  = 1'b1;
        pk.use_rs1     = 1'b1;
        range_bad      = !fits_u5(imm);
      end
      FMT_S: begin
        pk.bits[31:25] = imm[11:5];
        pk.bits[11:7]  = imm[4:0];
        pk.use_funct3  = 1'b1;
        pk.use_rs1     = 1'b1;
        pk.use_rs2     = 1'b1;
        range_bad      = !fits_s12($signed(imm));
      end
      FMT_B: begin
        // Decoder keeps the branch offset in half-word units, so imm[0] is a real bit here.
        pk.bits[31]    = imm[11];
        pk.bits[7]     = imm[10];
        pk.bits[30:25] = imm[9:4];
        pk.bits[11:8]  = imm[3:0];
        pk.use_funct3  = 1'b1;
        pk.use_rs1     = 1'b1;
        pk.use_rs2     = 1'b1;
        range_bad      = !fits_s12($signed(imm));
      end
      FMT_U: begin
        pk.bits[31:12] = imm[19:0];
        pk.use_rd      = 1'b1;
        range_bad      = !fits_s20($signed(imm));
      end
      FMT_J: begin
        pk.bits[31]    = imm[19];
        pk.bits[19:12] = imm[18:11];
        pk.bits[20]    = imm[10];
        pk.bits[30:21] = imm[9:0];
        pk.use_rd      = 1'b1;
        range_bad      = !fits_s20($signed(imm));
      end
      FMT_R: begin
        pk.bits[31:25] = funct7;
        pk.use_rd      = 1'b1;
        pk.use_funct3  = 1'b1;
        pk.use_rs1     = 1'b1;
        pk.use_rs2     = 1'b1;
      end
      default: begin
`ifdef IMM_RANGE_CHECK_EN
        pk.use_op      = 1'b0;
        range_bad      = 1'b1;
`else
        pk.bits[31:25] = funct7;
        pk.use_rd      = 1'b1;
        pk.use_funct3  = 1'b1;
        pk.use_rs1     = 1'b1;
        pk.use_rs2     = 1'b1;
`endif
      end
    endcase
`ifdef IMM_RANGE_CHECK_EN
    pk.err = range_bad;
`else
    pk.err = 1'b0;
`endif
  end

`ifndef IMM_RANGE_CHECK_EN
  logic unused_range_bad;
  assign unused_range_bad = range_bad;
`endif

endmodule

// File: rtl/imm_inst_encoder.sv
// RV32I instruction encoder with valid/ready handshake, 1-entry skid buffer and write-address counter.
// Define IMM_RANGE_CHECK_EN to flag unrepresentable immediates and unsupported opcodes on out_err.
module imm_inst_encoder
  import imm_inst_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  pack_t       pk_p0;
  logic [31:0] enc_inst_p0;
  logic        enc_err_p0;

  logic        skid_vld_p1;
  logic [31:0] skid_inst_p1;
  logic        skid_err_p1;
  logic        in_ready_q;

  logic        accept;
  logic        drain;
  logic        out_free;

  imm_pack u_pack (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .pk     (pk_p0)
  );

  // Stage p0: merge plain register/funct fields with the packed immediate bits.
  always_comb begin
    enc_inst_p0 = pk_p0.bits;
    if (pk_p0.use_op)     enc_inst_p0[6:0]   = opcode;
    if (pk_p0.use_rd)     enc_inst_p0[11:7]  = rd;
    if (pk_p0.use_funct3) enc_inst_p0[14:12] = funct3;
    if (pk_p0.use_rs1)    enc_inst_p0[19:15] = rs1;
    if (pk_p0.use_rs2)    enc_inst_p0[24:20] = rs2;
    enc_err_p0 = pk_p0.err;
  end

  assign in_ready = in_ready_q;
  assign accept   = in_valid && in_ready_q;
  assign drain    = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;

  // Stage p1: output register, skid occupancy and write address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_inst    <= '0;
      out_err     <= 1'b0;
      out_addr    <= BASE_ADDR;
      skid_vld_p1 <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (drain) out_addr <= out_addr + ADDR_W'(4);
      if (out_free) begin
        // The skid entry is older than anything arriving now; it is always promoted first.
        if (skid_vld_p1) begin
          out_valid   <= 1'b1;
          out_inst    <= skid_inst_p1;
          out_err     <= skid_err_p1;
          skid_vld_p1 <= 1'b0;
          in_ready_q  <= 1'b1;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_inst  <= enc_inst_p0;
          out_err   <= enc_err_p0;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_vld_p1 <= 1'b1;
        in_ready_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!out_free && accept) begin
      skid_inst_p1 <= enc_inst_p0;
      skid_err_p1  <= enc_err_p0;
    end
  end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Directed and randomized bench for imm_inst_encoder against a spec-level encode/decode model.
module tb_imm_inst_encoder;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0100;
`ifdef IMM_RANGE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_addr;

  imm_inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    int x;
    x = int'(v & ((32'd1 << bits) - 1));
    if (x >= (1 << (bits - 1))) x = x - (1 << bits);
    return x;
  endfunction

  // Spec-level encoder: field positions by shifting, legality by signed integer ranges.
  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] frd,
      input logic [4:0] frs1, input logic [4:0] frs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im, output logic [31:0] inst, output logic err);
    logic [31:0] o, d, s1, s2, t3, t7;
    int s;
    o = 32'(op); d = 32'(frd) << 7; s1 = 32'(frs1) << 15; s2 = 32'(frs2) << 20;
    t3 = 32'(f3) << 12; t7 = 32'(f7) << 25;
    s = int'(im);
    err = 1'b0;
    case (op)
      7'h03, 7'h67: begin
        inst = ((im & 32'hFFF) << 20) | s1 | t3 | d | o;
        err = (s < -2048) || (s > 2047);
      end
      7'h13: begin
        if (f3 == 3'd5) begin
          inst = t7 | ((im & 32'h1F) << 20) | s1 | t3 | d | o;
          err = im > 32'd31;
        end else begin
          inst = ((im & 32'hFFF) << 20) | s1 | t3 | d | o;
          err = (s < -2048) || (s > 2047);
        end
      end
      7'h23: begin
        inst = (((im >> 5) & 32'h7F) << 25) | s2 | s1 | t3 | ((im & 32'h1F) << 7) | o;
        err = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        inst = (((im >> 11) & 1) << 31) | (((im >> 10) & 1) << 7) |
               (((im >> 4) & 63) << 25) | ((im & 15) << 8) | s2 | s1 | t3 | o;
        err = (s < -2048) || (s > 2047);
      end
      7'h37, 7'h17: begin
        inst = ((im & 32'hFFFFF) << 12) | d | o;
        err = (s < -524288) || (s > 524287);
      end
      7'h6F: begin
        inst = (((im >> 19) & 1) << 31) | (((im >> 11) & 255) << 12) |
               (((im >> 10) & 1) << 20) | ((im & 1023) << 21) | d | o;
        err = (s < -524288) || (s > 524287);
      end
      7'h33: inst = t7 | s2 | s1 | t3 | d | o;
      default: begin
        inst = CHK ? 32'h0 : (t7 | s2 | s1 | t3 | d | o);
        err = 1'b1;
      end
    endcase
    if (!CHK) err = 1'b0;
  endfunction

  // Core decoder convention, written independently of the encoder.
  function automatic logic [31:0] ref_decode(input logic [31:0] w);
    logic [31:0] v;
    case (w & 32'h7F)
      32'h03, 32'h67: v = sext(w >> 20, 12);
      32'h13: v = (((w >> 12) & 7) == 5) ? ((w >> 20) & 31) : sext(w >> 20, 12);
      32'h23: v = sext((((w >> 25) & 127) << 5) | ((w >> 7) & 31), 12);
      32'h63: v = sext((((w >> 31) & 1) << 11) | (((w >> 7) & 1) << 10) |
                       (((w >> 25) & 63) << 4) | ((w >> 8) & 15), 12);
      32'h37, 32'h17: v = sext(w >> 12, 20);
      32'h6F: v = sext((((w >> 31) & 1) << 19) | (((w >> 12) & 255) << 11) |
                       (((w >> 20) & 1) << 10) | ((w >> 21) & 1023), 20);
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic drive(input logic [6:0] op, input logic [4:0] frd, input logic [4:0] frs1,
      input logic [4:0] frs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    opcode = op; rd = frd; rs1 = frs1; rs2 = frs2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  // One word with out_ready high: accept, then check the registered output one cycle later.
  task automatic do_one(input string tag, input logic [6:0] op, input logic [4:0] frd,
      input logic [4:0] frs1, input logic [4:0] frs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im, output logic [31:0] got);
    logic [31:0] ei;
    logic ee;
    ref_encode(op, frd, frs1, frs2, f3, f7, im, ei, ee);
    @(negedge clk);
    drive(op, frd, frs1, frs2, f3, f7, im);
    out_ready = 1'b1;
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "/valid"}, 32'(out_valid), 32'd1);
    chk({tag, "/inst"}, out_inst, ei);
    chk({tag, "/err"}, 32'(out_err), 32'(ee));
    chk({tag, "/addr"}, out_addr, exp_addr);
    got = out_inst;
    exp_addr = exp_addr + 32'd4;
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic [31:0] got, ea, eb, im;
    logic ee;
    logic [6:0] op;
    logic [2:0] f3;
    int k;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_addr = BASE;
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    chk("rst/out_addr", out_addr, BASE);
    chk("rst/out_inst", out_inst, 32'd0);
    chk("rst/out_err", 32'(out_err), 32'd0);

    do_one("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, got);
    chk("addi/lit", got, 32'hFFF0_0093);
    do_one("sw", 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, got);
    chk("sw/lit", got, 32'h0020_A423);
    do_one("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345, got);
    chk("lui/lit", got, 32'h1234_52B7);
    do_one("beq", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, got);
    chk("beq/lit", got, 32'h0000_0463);
    chk("beq/decode", ref_decode(got), 32'd4);

    do_one("addi2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, got);
    chk("addi2048/lit", got, 32'h8000_0093);
    do_one("srai32", 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd32, got);
    chk("srai32/lit", got, 32'h4002_5193);
    do_one("badop", 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234, got);
    chk("badop/lit", got, CHK ? 32'h0 : 32'h7F);

    for (int i = 0; i < 1000; i++) begin
      op = ops[$urandom_range(0, 8)];
      f3 = 3'($urandom_range(0, 7));
      if (op == 7'h13 && f3 == 3'd5) im = $urandom_range(0, 31);
      else if (op == 7'h37 || op == 7'h17 || op == 7'h6F) im = $urandom_range(0, 1048575) - 524288;
      else if (op == 7'h33) im = $urandom;
      else im = $urandom_range(0, 4095) - 2048;
      do_one("rt", op, 5'($urandom), 5'($urandom), 5'($urandom), f3, 7'($urandom), im, got);
      if (op != 7'h33) chk("rt/decode", ref_decode(got), im);
    end

    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 9);
      op = (k == 9) ? 7'($urandom) : ops[k];
      im = $urandom_range(0, 1) ? $urandom : ($urandom_range(0, 80) - 40);
      do_one("any", op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), im, got);
    end

    // Backpressure: two words stall in output + skid, then drain in order.
    @(negedge clk);
    out_ready = 1'b0;
    drive(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5);
    ref_encode(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5, ea, ee);
    @(posedge clk);
    #1 drive(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE);
    ref_encode(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE, eb, ee);
    chk("bp/in_ready_first", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp/in_ready_full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("bp/hold_valid", 32'(out_valid), 32'd1);
      chk("bp/hold_inst", out_inst, ea);
      chk("bp/hold_addr", out_addr, exp_addr);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp/second_valid", 32'(out_valid), 32'd1);
    chk("bp/second_inst", out_inst, eb);
    chk("bp/second_addr", out_addr, exp_addr + 32'd4);
    chk("bp/in_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp/no_dup", 32'(out_valid), 32'd0);
    chk("bp/addr_after", out_addr, exp_addr + 32'd8);
    exp_addr = exp_addr + 32'd8;

    // Reset with both entries occupied.
    out_ready = 1'b0;
    drive(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
    @(posedge clk);
    #1 drive(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rst2/full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2/out_valid", 32'(out_valid), 32'd0);
    chk("rst2/in_ready", 32'(in_ready), 32'd1);
    chk("rst2/out_addr", out_addr, BASE);
    exp_addr = BASE;
    do_one("post_rst", 7'h03, 5'd9, 5'd10, 5'd0, 3'd2, 7'd0, 32'hFFFF_FFF0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
